mger_pp_reduce: RTL and testbench

MGER_PP_REDUCE -- requirements
Module: mger_pp_reduce

---
 rtl/mger_pkg.sv | 27 ++
 rtl/mger_pp_column.sv | 26 ++
 rtl/mger_pp_reduce.sv | 121 ++++++++++++
 tb/tb_mger_pp_reduce.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mger_pkg.sv
// Shared constants and types for the MGER multiplier front end and its
// error-recovery stage.
package mger_pkg;

  localparam int OP_W            = 8;
  localparam int RES_W           = 16;
  localparam int APPROX_COLS_DEF = 12;
  localparam int CNT_W           = 4;
  localparam int OP_IDX_W        = 3;

  typedef struct packed {
    logic             or_bit;
    logic             multi_flag;
    logic [CNT_W-1:0] count;
  } col_t;

  typedef col_t [RES_W-1:0] cols_t;

  function automatic col_t col_summary(input logic [CNT_W-1:0] cnt);
    col_t c;
    c.or_bit     = (cnt != '0);
    c.multi_flag = (cnt > CNT_W'(1));
    c.count      = cnt;
    return c;
  endfunction

endpackage

// File: rtl/mger_pp_column.sv
// Population count of the partial products a[j]&b[i] that land in one
// result column (i+j == COL), summarised as {or_bit, multi_flag, count}.
module mger_pp_column
  import mger_pkg::*;
#(
  parameter int COL = 0
) (
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output col_t            col
);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < OP_W; i++) begin
      if ((COL - i) >= 0 && (COL - i) < OP_W) begin
        cnt = cnt + CNT_W'(a[OP_IDX_W'(COL - i)] & b[i]);
      end
    end
  end

  assign col = col_summary(cnt);

endmodule

// File: rtl/mger_pp_reduce.sv
// Two-stage partial-product reduction: exact product, or an OR-compressed low
// part with an error vector plus an exact high part, for the recovery stage.
module mger_pp_reduce
  import mger_pkg::*;
#(
  parameter int APPROX_COLS = APPROX_COLS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] s,
  output logic [RES_W-1:0] e
);

  cols_t            cols_p0;
  logic [OP_W-1:0]  a_p1_q, a_p1_d;
  logic [OP_W-1:0]  b_p1_q, b_p1_d;
  logic             mode_p1_q, mode_p1_d;
  cols_t            cols_p1_q, cols_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [RES_W-1:0] s_q, s_d;
  logic [RES_W-1:0] e_q, e_d;
  logic             adv_p2, load_p1, load_p2;

  // Low columns carry only their OR; high columns are summed exactly with no
  // carry-in from below, so their low bits stay zero and never collide.
  function automatic logic [RES_W-1:0] approx_sum(input cols_t c);
    logic [RES_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < RES_W; k++) begin
      if (k < APPROX_COLS) acc[k] = c[k].or_bit;
      else acc = acc + (RES_W'(c[k].count) << k);
    end
    return acc;
  endfunction

  function automatic logic [RES_W-1:0] approx_err(input cols_t c);
    logic [RES_W-1:0] err;
    err = '0;
    for (int k = 0; k < RES_W; k++) begin
      if (k < APPROX_COLS) err[k] = c[k].multi_flag;
    end
    return err;
  endfunction

  for (genvar k = 0; k < RES_W; k++) begin : g_col
    mger_pp_column #(.COL(k)) u_col (
      .a  (a),
      .b  (b),
      .col(cols_p0[k])
    );
  end

  assign adv_p2    = !vld_p2_q || out_ready;
  assign in_ready  = !vld_p1_q || adv_p2;
  assign load_p1   = in_valid && in_ready;
  assign load_p2   = vld_p1_q && adv_p2;
  assign out_valid = vld_p2_q;
  assign s         = s_q;
  assign e         = e_q;

  always_comb begin
    vld_p1_d  = in_ready ? in_valid : vld_p1_q;
    vld_p2_d  = adv_p2 ? vld_p1_q : vld_p2_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    mode_p1_d = mode_p1_q;
    cols_p1_d = cols_p1_q;
    if (load_p1) begin
      a_p1_d    = a;
      b_p1_d    = b;
      mode_p1_d = approx_en;
      cols_p1_d = cols_p0;
    end
  end

  always_comb begin
    s_d = s_q;
    e_d = e_q;
    if (load_p2) begin
      if (mode_p1_q) begin
        s_d = approx_sum(cols_p1_q);
        e_d = approx_err(cols_p1_q);
      end else begin
        s_d = RES_W'(a_p1_q) * RES_W'(b_p1_q);
        e_d = '0;
      end
    end
  end

  // Stage 1 boundary: operands, mode and column summaries.
  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    mode_p1_q <= mode_p1_d;
    cols_p1_q <= cols_p1_d;
  end

  // Stage 2 boundary: s/e are cleared too so reset leaves the outputs at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      s_q      <= '0;
      e_q      <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      s_q      <= s_d;
      e_q      <= e_d;
    end
  end

endmodule

// File: tb/tb_mger_pp_reduce.sv
// Directed and randomized checks of mger_pp_reduce against a column-counting
// reference model.
module tb_mger_pp_reduce;

  localparam int AC = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic [15:0] e;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] s;
    logic [15:0] e;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] qa[64];
  logic [7:0] qb[64];
  logic       qm[64];

  mger_pp_reduce #(.APPROX_COLS(AC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .e        (e)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic m,
                                output logic [15:0] rs, output logic [15:0] re);
    int cnt[16];
    int hi;
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cnt[i+j] += int'(x[j] & y[i]);
    rs = '0;
    re = '0;
    if (!m) begin
      rs = 16'(int'(x) * int'(y));
    end else begin
      hi = 0;
      for (int k = 0; k < 16; k++) begin
        if (k < AC) begin
          rs[k] = (cnt[k] != 0);
          re[k] = (cnt[k] >= 2);
        end else begin
          hi += cnt[k] << k;
        end
      end
      rs = rs | (16'(hi >> AC) << AC);
    end
  endfunction

  task automatic single(input vec_t v, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    a = v.a;
    b = v.b;
    approx_en = v.m;
    in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat1_valid"}, 16'(out_valid), 16'h0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 16'(out_valid), 16'h1);
    check({tag, "_s"}, s, v.s);
    check({tag, "_e"}, e, v.e);
  endtask

  task automatic run_stream(input int n, input bit rnd, input string tag);
    int sent;
    int got;
    int cyc;
    logic [15:0] es, ee;
    sent = 0;
    got = 0;
    cyc = 0;
    while (cyc < 2000 && got < n) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= 3);
      in_valid = (sent < n) && (!rnd || ($urandom_range(0, 3) != 0));
      if (sent < n) begin
        a = qa[sent];
        b = qb[sent];
        approx_en = qm[sent];
      end
      #1;
      if (!rnd && cyc == 2) begin
        check({tag, "_stall_in_ready"}, 16'(in_ready), 16'h0);
        check({tag, "_stall_accepts"}, 16'(sent), 16'd2);
      end
      if (out_valid) begin
        model(qa[got], qb[got], qm[got], es, ee);
        check({tag, "_s"}, s, es);
        check({tag, "_e"}, e, ee);
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check({tag, "_delivered"}, 16'(got), 16'(n));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check({tag, "_no_extra"}, 16'(out_valid), 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'h0000};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 16'hBFFF, 16'h0FFE};
    tbl[2] = '{8'h03, 8'h01, 1'b1, 16'h0003, 16'h0000};
    tbl[3] = '{8'h80, 8'h80, 1'b1, 16'h4000, 16'h0000};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000};
    tbl[5] = '{8'h03, 8'h03, 1'b1, 16'h0007, 16'h0002};
    tbl[6] = '{8'h03, 8'h03, 1'b0, 16'h0009, 16'h0000};
    tbl[7] = '{8'h05, 8'h05, 1'b1, 16'h0015, 16'h0004};
    tbl[8] = '{8'hF0, 8'hF0, 1'b1, 16'hBF00, 16'h0E00};
    tbl[9] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 16'h0000};

    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_s", s, 16'h0);
    check("rst_e", e, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 16'(in_ready), 16'h1);

    for (int i = 0; i < 10; i++) single(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      qa[i] = tbl[i].a;
      qb[i] = tbl[i].b;
      qm[i] = tbl[i].m;
    end
    run_stream(4, 1'b0, "stall");

    @(negedge clk);
    out_ready = 1'b0;
    a = tbl[0].a; b = tbl[0].b; approx_en = tbl[0].m;
    in_valid = 1'b1;
    @(negedge clk);
    a = tbl[1].a; b = tbl[1].b; approx_en = tbl[1].m;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("midrst_full_valid", 16'(out_valid), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0);
    check("midrst_s", s, 16'h0);
    check("midrst_e", e, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("midrst_in_ready", 16'(in_ready), 16'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("midrst_no_stale", 16'(out_valid), 16'h0);
    end
    single(tbl[5], "after_rst");

    for (int i = 0; i < 60; i++) begin
      qa[i] = 8'($urandom_range(0, 255));
      qb[i] = 8'($urandom_range(0, 255));
      qm[i] = 1'($urandom_range(0, 1));
    end
    run_stream(60, 1'b1, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
